// File: rtl/alu_pkg.sv
// Shared encodings for param_alu: opcodes, multiply sequencer states and flag bit positions.
package alu_pkg;

  typedef logic [2:0] op_t;

  localparam op_t OP_ADD = 3'b000;
  localparam op_t OP_SUB = 3'b001;
  localparam op_t OP_AND = 3'b010;
  localparam op_t OP_OR  = 3'b011;
  localparam op_t OP_XOR = 3'b100;
  localparam op_t OP_SHL = 3'b101;
  localparam op_t OP_SHR = 3'b110;
  localparam op_t OP_MUL = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_WB   = 2'd2
  } state_t;

  localparam int FLAG_CY  = 0;
  localparam int FLAG_Z   = 1;
  localparam int FLAG_N   = 2;
  localparam int FLAG_V   = 3;
  localparam int FLAG_CNT = 4;

endpackage

// File: rtl/param_alu_if.sv
// Control-word and status signals between the decoder and param_alu.
interface param_alu_if;
  import alu_pkg::*;

  logic ai;
  logic bi;
  logic ao;
  logic bo;
  logic eo;
  logic fi;
  logic go;
  op_t  op;
  logic busy;
  logic cy;
  logic z;
  logic n;
  logic v;

  modport master (
    output ai, bi, ao, bo, eo, fi, go, op,
    input  busy, cy, z, n, v
  );

  modport slave (
    input  ai, bi, ao, bo, eo, fi, go, op,
    output busy, cy, z, n, v
  );

endinterface

// File: rtl/seq_multiplier.sv
// Shift-add multiplier: captures operands on start, one partial product per cycle for WIDTH cycles.
// done is high during the cycle whose closing edge adds the last partial product.
module seq_multiplier
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int            CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] INC  = CW'(1);

  logic               run;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;

  assign done = run && (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run     <= 1'b0;
      cnt     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      product <= '0;
    end else if (start) begin
      run     <= 1'b1;
      cnt     <= '0;
      mcand   <= {{WIDTH{1'b0}}, a};
      mplier  <= b;
      product <= '0;
    end else if (run) begin
      // Multiplicand walks left while the multiplier bit under test walks into bit 0.
      if (mplier[0]) begin
        product <= product + mcand;
      end
      mcand  <= {mcand[2*WIDTH-2:0], 1'b0};
      mplier <= {1'b0, mplier[WIDTH-1:1]};
      cnt    <= cnt + INC;
      if (done) begin
        run <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/tri_state_buffer.sv
// Drives d onto a shared bus while en is high, otherwise releases it.
module tri_state_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output wire  [WIDTH-1:0] q
);

  assign q = en ? d : {WIDTH{1'bz}};

endmodule

// File: rtl/param_alu.sv
// WIDTH-bit bus ALU: A/B operand registers, combinational result, registered flags, sequential multiply.
// Multiply holds busy for WIDTH+1 cycles; all bus loads, drives, flag latches and starts are ignored meanwhile.
module param_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  inout  wire  [WIDTH-1:0] bus,
  param_alu_if.slave       ctl
);

  localparam int             MSB = WIDTH - 1;
  localparam logic [WIDTH:0] ONE = (WIDTH + 1)'(1);

  state_t               state;
  logic [WIDTH-1:0]     a_q;
  logic [WIDTH-1:0]     b_q;
  logic [WIDTH-1:0]     result;
  logic [WIDTH:0]       sum;
  logic                 res_cy;
  logic                 res_v;
  logic [FLAG_CNT-1:0]  flags;
  logic                 idle;
  logic                 is_mul;
  logic                 start;
  logic                 mul_done;
  logic [2*WIDTH-1:0]   product;
  logic [WIDTH-1:0]     prod_lo;
  logic [WIDTH-1:0]     prod_hi;
  logic                 a_oe;
  logic                 b_oe;
  logic                 e_oe;

  assign idle    = (state == ST_IDLE);
  assign is_mul  = (ctl.op == OP_MUL);
  assign start   = idle && ctl.go && is_mul;
  assign prod_lo = product[WIDTH-1:0];
  assign prod_hi = product[2*WIDTH-1:WIDTH];

  always_comb begin
    sum    = '0;
    result = '0;
    res_cy = 1'b0;
    res_v  = 1'b0;
    case (ctl.op)
      OP_ADD: begin
        sum    = {1'b0, a_q} + {1'b0, b_q};
        result = sum[WIDTH-1:0];
        res_cy = sum[WIDTH];
        res_v  = (a_q[MSB] == b_q[MSB]) && (result[MSB] != a_q[MSB]);
      end
      OP_SUB: begin
        // Two's-complement subtract: carry out set means no borrow.
        sum    = {1'b0, a_q} + {1'b0, ~b_q} + ONE;
        result = sum[WIDTH-1:0];
        res_cy = sum[WIDTH];
        res_v  = (a_q[MSB] != b_q[MSB]) && (result[MSB] != a_q[MSB]);
      end
      OP_AND: result = a_q & b_q;
      OP_OR:  result = a_q | b_q;
      OP_XOR: result = a_q ^ b_q;
      OP_SHL: begin
        result = {a_q[WIDTH-2:0], 1'b0};
        res_cy = a_q[MSB];
      end
      OP_SHR: begin
        result = {1'b0, a_q[WIDTH-1:1]};
        res_cy = a_q[0];
      end
      default: result = '0;
    endcase
  end

  seq_multiplier #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a_q),
    .b       (b_q),
    .done    (mul_done),
    .product (product)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      a_q   <= '0;
      b_q   <= '0;
      flags <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (ctl.ai) begin
            a_q <= bus;
          end
          if (ctl.bi) begin
            b_q <= bus;
          end
          if (ctl.fi && !is_mul) begin
            flags[FLAG_CY] <= res_cy;
            flags[FLAG_Z]  <= (result == '0);
            flags[FLAG_N]  <= result[MSB];
            flags[FLAG_V]  <= res_v;
          end
          if (start) begin
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (mul_done) begin
            state <= ST_WB;
          end
        end
        ST_WB: begin
          a_q            <= prod_lo;
          b_q            <= prod_hi;
          flags[FLAG_CY] <= (prod_hi != '0);
          flags[FLAG_Z]  <= (product == '0);
          flags[FLAG_N]  <= 1'b0;
          flags[FLAG_V]  <= 1'b0;
          state          <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign ctl.busy = !idle;
  assign ctl.cy   = flags[FLAG_CY];
  assign ctl.z    = flags[FLAG_Z];
  assign ctl.n    = flags[FLAG_N];
  assign ctl.v    = flags[FLAG_V];

  // Drivers are released in reset and for the whole multiply, whatever the enables say.
  assign a_oe = idle && !rst && ctl.ao;
  assign b_oe = idle && !rst && ctl.bo;
  assign e_oe = idle && !rst && ctl.eo;

  tri_state_buffer #(.WIDTH(WIDTH)) u_a_drv (.en(a_oe), .d(a_q),    .q(bus));
  tri_state_buffer #(.WIDTH(WIDTH)) u_b_drv (.en(b_oe), .d(b_q),    .q(bus));
  tri_state_buffer #(.WIDTH(WIDTH)) u_e_drv (.en(e_oe), .d(result), .q(bus));

endmodule

// File: tb/tb_param_alu.sv
// Scoreboard bench for param_alu at WIDTH=8: directed vectors push expectations, a negedge monitor checks them.
module tb_param_alu;
  import alu_pkg::*;

  localparam int W = 8;

  typedef struct {
    string        name;
    logic         chk_bus;
    logic [W-1:0] bus;
    logic         chk_flags;
    logic [3:0]   flags;
    logic         busy;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  wire  [W-1:0] bus;
  logic [W-1:0] drv_val;
  logic         drv_en;
  logic         sample;
  logic         finish_chk;

  exp_t exp_q[$];
  int   len_q[$];
  exp_t mon_e;
  int   busy_len = 0;
  int   exp_len;
  int   compared = 0;
  int   mismatched = 0;
  logic [3:0] flags_now;

  assign bus = drv_en ? drv_val : {W{1'bz}};

  param_alu_if ctl ();

  param_alu #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .ctl (ctl)
  );

  always #5 clk = ~clk;

  assign flags_now = {ctl.cy, ctl.z, ctl.n, ctl.v};

  always @(negedge clk) begin
    if (ctl.busy) begin
      busy_len++;
    end else if (busy_len != 0) begin
      compared++;
      exp_len = -1;
      if (len_q.size() != 0) exp_len = len_q.pop_front();
      if (busy_len != exp_len) begin
        mismatched++;
        $display("FAIL busy_len: busy lasted %0d cycles, expected %0d", busy_len, exp_len);
      end
      busy_len = 0;
    end
    if (sample) begin
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("FAIL scoreboard: sample taken with no expectation queued");
      end else begin
        mon_e = exp_q.pop_front();
        if ((ctl.busy !== mon_e.busy) ||
            (mon_e.chk_bus && (bus !== mon_e.bus)) ||
            (mon_e.chk_flags && (flags_now !== mon_e.flags))) begin
          mismatched++;
          $display("FAIL %s: got bus=%h flags(cy,z,n,v)=%b busy=%b, expected bus=%h(chk %0b) flags=%b(chk %0b) busy=%b",
                   mon_e.name, bus, flags_now, ctl.busy, mon_e.bus, mon_e.chk_bus,
                   mon_e.flags, mon_e.chk_flags, mon_e.busy);
        end
      end
    end
    if (finish_chk) begin
      compared++;
      if (exp_q.size() != 0 || len_q.size() != 0) begin
        mismatched++;
        $display("FAIL drain: %0d samples and %0d busy windows left, expected 0 and 0",
                 exp_q.size(), len_q.size());
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
    ctl.ai = 1'b0; ctl.bi = 1'b0; ctl.ao = 1'b0; ctl.bo = 1'b0;
    ctl.eo = 1'b0; ctl.fi = 1'b0; ctl.go = 1'b0;
    drv_en = 1'b0; sample = 1'b0; finish_chk = 1'b0;
  endtask

  task automatic expect_obs(input string name, input logic cb, input logic [W-1:0] eb,
                            input logic cf, input logic [3:0] ef, input logic ebusy);
    exp_t e;
    e.name = name; e.chk_bus = cb; e.bus = eb;
    e.chk_flags = cf; e.flags = ef; e.busy = ebusy;
    exp_q.push_back(e);
    sample = 1'b1;
  endtask

  task automatic put(input logic [W-1:0] val);
    drv_en  = 1'b1;
    drv_val = val;
  endtask

  task automatic load_a(input logic [W-1:0] val);
    put(val); ctl.ai = 1'b1; cyc();
  endtask

  task automatic load_b(input logic [W-1:0] val);
    put(val); ctl.bi = 1'b1; cyc();
  endtask

  // Result on the bus this cycle, flags one cycle after the FI edge.
  task automatic alu_op(input string name, input op_t op, input logic [W-1:0] eb, input logic [3:0] ef);
    ctl.op = op; ctl.eo = 1'b1; ctl.fi = 1'b1;
    expect_obs({name, "_bus"}, 1'b1, eb, 1'b0, 4'b0000, 1'b0);
    cyc();
    expect_obs({name, "_flags"}, 1'b0, '0, 1'b1, ef, 1'b0);
    cyc();
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40 && ctl.busy; i++) cyc();
  endtask

  initial begin
    rst = 1'b1; drv_en = 1'b0; drv_val = '0; sample = 1'b0; finish_chk = 1'b0;
    ctl.ai = 1'b0; ctl.bi = 1'b0; ctl.ao = 1'b0; ctl.bo = 1'b0;
    ctl.eo = 1'b0; ctl.fi = 1'b0; ctl.go = 1'b0; ctl.op = OP_ADD;
    repeat (2) @(posedge clk);
    #1;
    expect_obs("reset_in_rst", 1'b0, '0, 1'b1, 4'b0000, 1'b0);
    cyc();
    rst = 1'b0;
    ctl.ao = 1'b1; expect_obs("reset_a", 1'b1, 8'h00, 1'b1, 4'b0000, 1'b0); cyc();
    ctl.bo = 1'b1; expect_obs("reset_b", 1'b1, 8'h00, 1'b1, 4'b0000, 1'b0); cyc();

    load_a(8'h7F); load_b(8'h01);
    alu_op("add", OP_ADD, 8'h80, 4'b0011);
    load_a(8'h05); load_b(8'h05);
    alu_op("sub", OP_SUB, 8'h00, 4'b1100);
    load_a(8'h81);
    alu_op("shl", OP_SHL, 8'h02, 4'b1000);
    alu_op("shr", OP_SHR, 8'h40, 4'b1000);
    load_b(8'h81);
    alu_op("xor", OP_XOR, 8'h00, 4'b0100);
    load_b(8'h0F);
    alu_op("and", OP_AND, 8'h01, 4'b0000);
    alu_op("or",  OP_OR,  8'h8F, 4'b0010);
    // FI with MUL selected leaves the OR flags alone; MUL reads as zero.
    alu_op("fi_mul_ignored", OP_MUL, 8'h00, 4'b0010);
    ctl.op = OP_ADD; ctl.go = 1'b1; cyc();
    expect_obs("go_add_ignored", 1'b0, '0, 1'b0, 4'b0000, 1'b0); cyc();

    load_a(8'h0C); load_b(8'h0D);
    ctl.op = OP_MUL; ctl.go = 1'b1; len_q.push_back(W + 1); cyc();
    expect_obs("mul1_busy", 1'b0, '0, 1'b0, 4'b0000, 1'b1); cyc();
    wait_idle();
    ctl.ao = 1'b1; expect_obs("mul1_a", 1'b1, 8'h9C, 1'b1, 4'b0000, 1'b0); cyc();
    ctl.bo = 1'b1; expect_obs("mul1_b", 1'b1, 8'h00, 1'b1, 4'b0000, 1'b0); cyc();

    load_a(8'hFF); load_b(8'hFF);
    ctl.op = OP_MUL; ctl.go = 1'b1; len_q.push_back(W + 1); cyc();
    put(8'h55); ctl.ai = 1'b1; ctl.bi = 1'b1; ctl.fi = 1'b1;
    expect_obs("mul2_load_ignored", 1'b0, '0, 1'b0, 4'b0000, 1'b1); cyc();
    ctl.go = 1'b1; cyc();
    // Bench drives zero; any DUT drive of A (0xFF) would corrupt it.
    put(8'h00); ctl.ao = 1'b1; ctl.bo = 1'b1; ctl.eo = 1'b1;
    expect_obs("mul2_bus_released", 1'b1, 8'h00, 1'b0, 4'b0000, 1'b1); cyc();
    wait_idle();
    ctl.ao = 1'b1; expect_obs("mul2_a", 1'b1, 8'h01, 1'b1, 4'b1000, 1'b0); cyc();
    ctl.bo = 1'b1; expect_obs("mul2_b", 1'b1, 8'hFE, 1'b1, 4'b1000, 1'b0); cyc();

    load_a(8'h0C); load_b(8'h0D);
    ctl.op = OP_MUL; ctl.go = 1'b1; len_q.push_back(4); cyc();
    repeat (4) cyc();
    rst = 1'b1;
    put(8'h00); ctl.ao = 1'b1;
    expect_obs("rst_mid_mul", 1'b1, 8'h00, 1'b1, 4'b0000, 1'b0); cyc();
    rst = 1'b0;
    ctl.ao = 1'b1; expect_obs("rst_a", 1'b1, 8'h00, 1'b1, 4'b0000, 1'b0); cyc();
    ctl.bo = 1'b1; expect_obs("rst_b", 1'b1, 8'h00, 1'b1, 4'b0000, 1'b0); cyc();

    repeat (3) cyc();
    finish_chk = 1'b1;
    cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/param_alu.md
# param_alu

Parametrised successor to the 8-bit add/subtract ALU: a WIDTH-bit ALU with its own A/B operand registers, eight operations (arithmetic, logic, shifts and a multi-cycle shift-add multiply), and a registered flag set (carry, zero, negative, overflow). It sits on the shared tri-state bus exactly like the existing ALU and is driven by the control-word decoder. Multiply is a WIDTH-cycle sequential operation with a BUSY indication that the controller must honour.

## Interface
- WIDTH, 8, datapath and bus width (≥2)
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high; clears all state
- bus  inout  WIDTH  shared system bus
- AI / BI  in  1  load A / B from bus
- AO / BO  in  1  drive A / B onto bus
- EO  in  1  drive combinational result onto bus
- OP  in  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR, 111 MUL
- FI  in  1  latch flags from current result
- GO  in  1  start multiply (only honoured when OP=MUL and idle)
- BUSY  out  1  multiply in progress
- CY, Z, N, V  out  1 each  registered flags

## Operation
- Reset: A=B=0, flags=0, state IDLE, count 0, BUSY=0, bus released (high-Z). Reset mid-multiply aborts immediately, no partial write-back.
- Result (combinational, A/B registers): ADD A+B; SUB A+~B+1; AND/OR/XOR bitwise; SHL A<<1; SHR A>>1 logical; MUL result reads as 0 on bus.
- Flag rules: ADD/SUB CY = carry out of MSB (SUB: 1 = no borrow), V = signed overflow; SHL CY = A[WIDTH-1]; SHR CY = A[0]; logic ops and shifts V=0; Z = result==0; N = result[WIDTH-1].
- FI in IDLE with OP≠MUL loads all four flags; FI with OP=MUL or while BUSY ignored.
- States: IDLE → RUN on GO && OP==MUL; RUN counts WIDTH cycles of shift-add on captured copies of A and B (2·WIDTH-bit accumulator); RUN → WB when count reaches WIDTH; WB → IDLE unconditionally.
- WB: A ← product[WIDTH-1:0], B ← product[2·WIDTH-1:WIDTH]; CY = high half ≠ 0; Z = full product == 0; N = V = 0. Flags update at WB without FI.
- While BUSY (RUN or WB): AI, BI, FI, GO ignored; AO, BO, EO ignored (bus not driven).
- GO with OP≠MUL: ignored. GO while BUSY: ignored, no restart.
- AI and BI together: both load the same bus value. Bus contention (multiple output enables here or elsewhere) is the controller's responsibility; no arbitration inside the block.

## Timing
- AI/BI: register updated at the edge where asserted; visible on AO/BO and result next cycle.
- EO/AO/BO: combinational drive, same cycle as enable.
- FI: flags valid after the edge where asserted.
- MUL: GO sampled at edge t; BUSY=1 from after t until after edge t+WIDTH+1; product in A/B and flags updated at edge t+WIDTH+1; new ops accepted from that cycle on (WIDTH+1 cycles busy total).
- BUSY is a registered output (decode of state), never combinational from GO.

## Structure
- Package alu_pkg: OP encodings as localparams, state encoding (IDLE, RUN, WB), flag bit indices.
- One sub-module: seq_multiplier (shift-add engine: captures operands, counter, accumulator, done pulse); param_alu owns registers, flags, result mux and bus drivers.
- Bus drivers reuse the existing tri_state_buffer; operand registers may reuse the existing register.

## Test plan (WIDTH=8)
- A=0x7F, B=0x01, OP=ADD, EO then FI -> bus 0x80; CY=0, Z=0, N=1, V=1.
- A=0x05, B=0x05, OP=SUB, FI -> result 0x00; CY=1, Z=1, N=0, V=0.
- A=0x81: OP=SHL -> 0x02, CY=1; OP=SHR -> 0x40, CY=1; OP=XOR with B=0x81 -> 0x00, Z=1, CY=0.
- A=0x0C, B=0x0D, GO, OP=MUL -> BUSY high 9 cycles, then A=0x9C, B=0x00, CY=0, Z=0; repeat with 0xFF×0xFF -> A=0x01, B=0xFE, CY=1.
- During MUL pulse AI with bus=0x55, GO again, AO -> A unchanged, no restart, bus undriven; product as above.
- rst asserted 4 cycles into MUL -> BUSY=0, A=B=0, flags=0 immediately (before next edge); bus high-Z.
